classificador_digito: RTL and testbench
=======================================

CLASSIFICADOR_DIGITO -- requirements
Module: classificador_digito

Interface
REQ-001 SHALL have parameter NUM_TPL, default 10, meaning the number of digit templates scanned (digits 0..NUM_TPL-1).
REQ-002 SHALL have parameter NUM_PIX, default 121, meaning the pixels per 11x11 image, scanned row-major.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port iStart, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL have port oPixAddr, output, 7 bits: image RAM address; data arrives one cycle later.
REQ-007 SHALL have port iPixData, input, 8 bits: image pixel for the previous cycle's oPixAddr.
REQ-008 SHALL have port oTplDigit, output, 4 bits: template ROM digit select.
REQ-009 SHALL have port oTplAddr, output, 7 bits: template ROM pixel address, always equal to oPixAddr.
REQ-010 SHALL have port iTplData, input, 8 bits: template pixel, with one cycle of latency.
REQ-011 SHALL have port oDiffA, output, 8 bits: operand A of the shared DiferencaEuclidiana unit, equal to iPixData.
REQ-012 SHALL have port oDiffB, output, 8 bits: operand B of the shared DiferencaEuclidiana unit, equal to iTplData.
REQ-013 SHALL have port iDiff, input, 8 bits: combinational difference returned by the shared unit.
REQ-014 SHALL have port oBusy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port oDone, output, 1 bit: one-cycle pulse when the result is valid.
REQ-016 SHALL have port oDigit, output, 4 bits: best-matching digit.
REQ-017 SHALL have port oScore, output, 16 bits: summed difference of the best match.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, CMP and DONE.
REQ-019 SHALL, in IDLE with iStart=1, clear the template index, pixel counter and accumulator, set best=16'hFFFF and bestDigit=0, and go to RUN.
REQ-020 SHALL, in RUN, drive oPixAddr = pixel counter (0..NUM_PIX-1, +1 per cycle) and oTplDigit = template index.
REQ-021 SHALL go from RUN to DRAIN after issuing address NUM_PIX-1.
REQ-022 SHALL add the zero-extended iDiff to the 16-bit accumulator in every cycle in which the data for an issued address is valid (RUN cycles 2..NUM_PIX, plus DRAIN).
REQ-023 SHALL add exactly NUM_PIX terms per template, with no overflow: the maximum is 121*255=30855.
REQ-024 SHALL, in CMP, load acc into best and the template index into bestDigit when acc < best (strict).
REQ-025 SHALL resolve ties to the lower digit.
REQ-026 SHALL, after CMP, clear the accumulator and pixel counter and increment the template index.
REQ-027 SHALL go from CMP to RUN when the template index < NUM_TPL-1, and otherwise go to DONE.
REQ-028 SHALL spend NUM_PIX+2 = 123 cycles per template.
REQ-029 SHALL, in DONE, assert oDone for one cycle, load oDigit=bestDigit and oScore=best, and return to IDLE.
REQ-030 SHALL make oDone rise exactly NUM_TPL*(NUM_PIX+2) = 1230 clock edges after the edge that samples iStart.
REQ-031 SHALL hold oDigit and oScore until the next DONE.
REQ-032 SHALL ignore iStart while oBusy=1, with no restart and no queueing.
REQ-033 SHALL let iStart held high continuously start a new scan in the cycle after DONE returns to IDLE.
REQ-034 SHALL drive oPixAddr, oTplAddr and oTplDigit to 0 in IDLE and DONE.

Reset
REQ-035 SHALL, on iRST_N low, immediately force state IDLE.
REQ-036 SHALL, on iRST_N low, immediately clear the counters and accumulator, set best=16'hFFFF, and set oBusy=0, oDone=0, oDigit=0, oScore=0 and all addresses to 0.
REQ-037 SHALL, on reset asserted mid-scan, abort the scan without an oDone pulse, and make the next scan start from template 0.
REQ-038 SHALL release reset cleanly: the first iStart after deassertion behaves as in REQ-019.

Verification
REQ-039 SHALL verify this scenario: image equal to the template-2 table, other templates differing -> oDone at edge 1230, oDigit=2, oScore=0.
REQ-040 SHALL verify this scenario: all-255 image, all-0 templates (shared unit returns |a-b|) -> oDigit=0, oScore=30855.
REQ-041 SHALL verify this scenario: templates 3 and 7 both equal to the image -> oDigit=3, oScore=0 (tie rule).
REQ-042 SHALL verify this scenario: iStart pulsed again at cycles 5 and 600 of a scan -> single oDone at edge 1230, result unchanged; oBusy high throughout.
REQ-043 SHALL verify this scenario: iRST_N low at cycle 400 -> oBusy=0, oDone never pulses, oDigit=0 and oScore=0; a new iStart then completes at edge 1230 with the correct result.
REQ-044 SHALL verify this scenario: address trace check -> oPixAddr steps 0..120 once per template with oTplDigit 0..9 in order, and oTplAddr==oPixAddr every cycle.

Source files
------------

// File: rtl/classificador_digito_if.sv
// Bus bundle for the digit classifier: start request, image RAM port,
// template ROM port, shared difference unit port and result signals.
//   slave  : the classifier side (classificador_digito)
//   master : the environment side (memories, difference unit, controller)
interface classificador_digito_if;
    logic        iStart;     // start request
    logic [6:0]  oPixAddr;   // image RAM address
    logic [7:0]  iPixData;   // image pixel, one cycle after oPixAddr
    logic [3:0]  oTplDigit;  // template ROM digit select
    logic [6:0]  oTplAddr;   // template ROM pixel address
    logic [7:0]  iTplData;   // template pixel, one cycle latency
    logic [7:0]  oDiffA;     // operand A of the shared difference unit
    logic [7:0]  oDiffB;     // operand B of the shared difference unit
    logic [7:0]  iDiff;      // difference returned by the shared unit
    logic        oBusy;      // high whenever not idle
    logic        oDone;      // one-cycle result-valid pulse
    logic [3:0]  oDigit;     // best-matching digit
    logic [15:0] oScore;     // summed difference of the best match

    modport slave (
        input  iStart, iPixData, iTplData, iDiff,
        output oPixAddr, oTplDigit, oTplAddr, oDiffA, oDiffB,
               oBusy, oDone, oDigit, oScore
    );

    modport master (
        output iStart, iPixData, iTplData, iDiff,
        input  oPixAddr, oTplDigit, oTplAddr, oDiffA, oDiffB,
               oBusy, oDone, oDigit, oScore
    );
endinterface

// File: rtl/classificador_digito.sv
// Nearest-template digit classifier. For each of NUM_TPL templates it streams
// the NUM_PIX image and template pixels, sums the per-pixel difference from
// an external shared unit, and keeps the template with the smallest sum
// (ties go to the lower digit).
//   iCLK   : clock, rising edge
//   iRST_N : asynchronous active-low reset
//   bus    : classificador_digito_if.slave (start, memory ports, diff unit,
//            busy/done/result)
module classificador_digito #(
    parameter int NUM_TPL = 10,
    parameter int NUM_PIX = 121
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    classificador_digito_if.slave bus
);

    localparam logic [6:0] PIX_LAST = 7'(NUM_PIX - 1);
    localparam logic [3:0] TPL_LAST = 4'(NUM_TPL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  pix_q, pix_d;
    logic [3:0]  tpl_q, tpl_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] best_q, best_d;
    logic [3:0]  best_dig_q, best_dig_d;
    logic        vld_q, vld_d;       // memory data on this cycle belongs to an issued address
    logic        done_q, done_d;
    logic [3:0]  digit_q, digit_d;
    logic [15:0] score_q, score_d;
    logic        better_s;
    logic [15:0] new_best_s;
    logic [3:0]  new_dig_s;

    // State and datapath registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            pix_q      <= 7'd0;
            tpl_q      <= 4'd0;
            acc_q      <= 16'd0;
            best_q     <= 16'hFFFF;
            best_dig_q <= 4'd0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= 4'd0;
            score_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            tpl_q      <= tpl_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            best_dig_q <= best_dig_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            digit_q    <= digit_d;
            score_q    <= score_d;
        end
    end

    // Strict less-than keeps the earlier (lower) digit on a tie
    always_comb begin
        better_s   = (acc_q < best_q);
        new_best_s = better_s ? acc_q : best_q;
        new_dig_s  = better_s ? tpl_q : best_dig_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        tpl_d      = tpl_q;
        best_d     = best_q;
        best_dig_d = best_dig_q;
        done_d     = 1'b0;
        digit_d    = digit_q;
        score_d    = score_q;
        // An address issued in RUN returns data on the following cycle
        vld_d      = (state_q == S_RUN);
        if (vld_q) begin
            acc_d = acc_q + {8'd0, bus.iDiff};
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
                    tpl_d      = 4'd0;
                    pix_d      = 7'd0;
                    acc_d      = 16'd0;
                    best_d     = 16'hFFFF;
                    best_dig_d = 4'd0;
                    state_d    = S_RUN;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_RUN: begin
                if (pix_q == PIX_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    pix_d   = pix_q + 7'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                best_d     = new_best_s;
                best_dig_d = new_dig_s;
                acc_d      = 16'd0;
                pix_d      = 7'd0;
                tpl_d      = tpl_q + 4'd1;
                if (tpl_q < TPL_LAST) begin
                    state_d = S_RUN;
                end else begin
                    // Result registers load on entry to DONE so they are valid with oDone
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    digit_d = new_dig_s;
                    score_d = new_best_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Addresses are only meaningful while streaming; parked at 0 otherwise
    always_comb begin
        if (state_q == S_RUN) begin
            bus.oPixAddr  = pix_q;
            bus.oTplDigit = tpl_q;
        end else begin
            bus.oPixAddr  = 7'd0;
            bus.oTplDigit = 4'd0;
        end
    end

    assign bus.oTplAddr = bus.oPixAddr;
    assign bus.oDiffA   = bus.iPixData;
    assign bus.oDiffB   = bus.iTplData;
    assign bus.oBusy    = (state_q != S_IDLE);
    assign bus.oDone    = done_q;
    assign bus.oDigit   = digit_q;
    assign bus.oScore   = score_q;

endmodule

// File: tb/tb_classificador_digito.sv
module tb_classificador_digito;

    localparam int NT = 10;
    localparam int NP = 121;
    localparam int T_SCAN = NT * (NP + 2);   // 1230

    logic clk;
    logic rst_n;
    classificador_digito_if bus();

    classificador_digito #(.NUM_TPL(NT), .NUM_PIX(NP)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    logic [7:0] img [0:NP-1];
    logic [7:0] tpl [0:NT-1][0:NP-1];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory models with one cycle of read latency
    always @(posedge clk) begin
        bus.iPixData <= img[bus.oPixAddr];
        bus.iTplData <= tpl[bus.oTplDigit][bus.oTplAddr];
    end

    // shared difference unit: |a-b|
    assign bus.iDiff = (bus.oDiffA > bus.oDiffB) ? (bus.oDiffA - bus.oDiffB)
                                                 : (bus.oDiffB - bus.oDiffA);

    typedef struct {
        int   kind;      // image/template pattern
        bit   pulses;    // extra iStart pulses at cycles 5 and 600
        bit   hold;      // iStart held high throughout
        int   rst_at;    // cycle to assert reset, -1 for none
        bit   use_model; // expected result from model rather than table
        int   exp_d;
        int   exp_s;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic setup(input int kind);
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
        for (int d = 0; d < NT; d++)
            for (int i = 0; i < NP; i++) tpl[d][i] = 8'($urandom_range(0, 255));
        case (kind)
            0, 2: begin
                for (int d = 0; d < NT; d++) begin
                    if ((kind == 0 && d == 2) || (kind == 2 && (d == 3 || d == 7))) begin
                        for (int i = 0; i < NP; i++) tpl[d][i] = img[i];
                    end else begin
                        tpl[d][0] = img[0] ^ 8'h80;
                    end
                end
            end
            1: begin
                for (int i = 0; i < NP; i++) img[i] = 8'd255;
                for (int d = 0; d < NT; d++)
                    for (int i = 0; i < NP; i++) tpl[d][i] = 8'd0;
            end
            4: begin
                for (int d = 1; d < NT; d++)
                    for (int i = 0; i < NP; i++) tpl[d][i] = tpl[0][i];
            end
            default: ;
        endcase
    endtask

    // reference: sum of absolute differences, lowest digit wins ties
    task automatic model(output int md, output int ms);
        int s;
        md = 0;
        ms = 65535;
        for (int d = 0; d < NT; d++) begin
            s = 0;
            for (int i = 0; i < NP; i++)
                s += (img[i] > tpl[d][i]) ? int'(img[i]) - int'(tpl[d][i])
                                          : int'(tpl[d][i]) - int'(img[i]);
            if (s < ms) begin
                ms = s;
                md = d;
            end
        end
    endtask

    task automatic run_scan(input vec_t v);
        int md, ms, ed, es;
        int tr_err = 0, busy_err = 0, done_cnt = 0, done_at = -1;
        int got_d = -1, got_s = -1;
        int t, p, ea, et;
        setup(v.kind);
        model(md, ms);
        ed = v.use_model ? md : v.exp_d;
        es = v.use_model ? ms : v.exp_s;
        @(negedge clk);
        bus.iStart = 1'b1;
        for (int m = 0; m <= T_SCAN + 2; m++) begin
            @(negedge clk);   // cycle following edge m
            if (m < T_SCAN) begin
                t = m / (NP + 2);
                p = m % (NP + 2);
                ea = (p < NP) ? p : 0;
                et = (p < NP) ? t : 0;
                if (bus.oPixAddr != 7'(ea) || bus.oTplDigit != 4'(et) ||
                    bus.oTplAddr != bus.oPixAddr) tr_err++;
                if (!bus.oBusy) busy_err++;
            end
            if (bus.oDone) begin
                done_cnt++;
                done_at = m;
                got_d = int'(bus.oDigit);
                got_s = int'(bus.oScore);
            end
            if (m == T_SCAN + 1) begin
                chk("busy_after_done", int'(bus.oBusy), 0);
                chk("digit_held", int'(bus.oDigit), ed);
                chk("score_held", int'(bus.oScore), es);
            end
            if (m == T_SCAN + 2) chk("busy_restart", int'(bus.oBusy), int'(v.hold));
            if (m == v.rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", int'(bus.oBusy), 0);
                chk("rst_done", int'(bus.oDone), 0);
                chk("rst_digit", int'(bus.oDigit), 0);
                chk("rst_score", int'(bus.oScore), 0);
                chk("rst_addr", int'(bus.oPixAddr) + int'(bus.oTplAddr) + int'(bus.oTplDigit), 0);
                bus.iStart = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
                repeat (T_SCAN + 10) begin
                    @(negedge clk);
                    if (bus.oDone || bus.oBusy) done_cnt++;
                end
                chk("rst_no_done", done_cnt, 0);
                chk("rst_trace", tr_err, 0);
                return;
            end
            bus.iStart = v.hold || (v.pulses && (m == 4 || m == 599));
        end
        bus.iStart = 1'b0;
        chk("trace", tr_err, 0);
        chk("busy_during_scan", busy_err, 0);
        chk("done_count", done_cnt, 1);
        chk("done_edge", done_at, T_SCAN);
        chk("digit", got_d, ed);
        chk("score", got_s, es);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, -1, 1'b0, 2, 0};
        vecs[1] = '{1, 1'b0, 1'b0, -1, 1'b0, 0, 30855};
        vecs[2] = '{2, 1'b0, 1'b0, -1, 1'b0, 3, 0};
        vecs[3] = '{0, 1'b1, 1'b0, -1, 1'b0, 2, 0};
        vecs[4] = '{3, 1'b0, 1'b0, -1, 1'b1, 0, 0};
        vecs[5] = '{4, 1'b0, 1'b0, -1, 1'b1, 0, 0};
        vecs[6] = '{3, 1'b0, 1'b0, 400, 1'b1, 0, 0};
        vecs[7] = '{3, 1'b0, 1'b0, -1, 1'b1, 0, 0};
        vecs[8] = '{3, 1'b1, 1'b1, -1, 1'b1, 0, 0};

        rst_n = 1'b0;
        bus.iStart = 1'b0;
        for (int i = 0; i < NP; i++) img[i] = 8'd0;
        for (int d = 0; d < NT; d++)
            for (int i = 0; i < NP; i++) tpl[d][i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bus.oBusy), 0);
        chk("reset_done", int'(bus.oDone), 0);
        chk("reset_digit", int'(bus.oDigit), 0);
        chk("reset_score", int'(bus.oScore), 0);
        chk("reset_addr", int'(bus.oPixAddr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 9; k++) run_scan(vecs[k]);

        // stop the back-to-back scan started by the held iStart
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_reset_busy", int'(bus.oBusy), 0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
